// File: rtl/bp_pwm_pkg.sv
// rtl/bp_pwm_pkg.sv - register map offsets and CTRL field positions for bp_pwm_multi
package bp_pwm_pkg;

  localparam int CTRL_OFS    = 0;
  localparam int PERIOD_OFS  = 1;
  localparam int DUTY_OFS    = 2;
  localparam int CH_STRIDE   = 2;
  localparam int CTRL_EN_LSB = 0;
  localparam int CTRL_OS_LSB = 8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_CTRL,
    REG_PERIOD,
    REG_DUTY
  } reg_kind_e;

endpackage

// File: rtl/bp_pwm_channel.sv
// rtl/bp_pwm_channel.sv - one PWM channel: counter, shadow/active swap, one-shot
module bp_pwm_channel #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 oneshot_i,
  input  logic                 per_we_i,
  input  logic                 duty_we_i,
  input  logic [CNT_WIDTH-1:0] wdata_i,
  output logic [CNT_WIDTH-1:0] per_sh_o,
  output logic [CNT_WIDTH-1:0] duty_sh_o,
  output logic                 pwm_o,
  output logic                 done_o,
  output logic                 clr_o
);

  logic [CNT_WIDTH-1:0] per_sh_q, duty_sh_q;
  logic [CNT_WIDTH-1:0] per_act_q, per_act_d;
  logic [CNT_WIDTH-1:0] duty_act_q, duty_act_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 os_q, os_d;
  logic                 pwm_q, pwm_d;
  logic                 done_q, done_d;

  // run_q is separate from en_i so a finished one-shot can restart if the MCU re-enables it
  always_comb begin
    cnt_d      = cnt_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    os_d       = os_q;
    run_d      = run_q;
    pwm_d      = pwm_q;
    done_d     = 1'b0;
    clr_o      = 1'b0;
    if (!en_i) begin
      run_d = 1'b0;
      cnt_d = '0;
      pwm_d = 1'b0;
    end else if (!run_q || cnt_q == per_act_q) begin
      if (run_q && os_q) begin
        run_d  = 1'b0;
        cnt_d  = '0;
        pwm_d  = 1'b0;
        done_d = 1'b1;
        clr_o  = 1'b1;
      end else begin
        run_d      = 1'b1;
        cnt_d      = '0;
        per_act_d  = per_sh_q;
        duty_act_d = duty_sh_q;
        os_d       = oneshot_i;
        pwm_d      = (duty_sh_q != '0);
      end
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      pwm_d = (cnt_d < duty_act_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_sh_q   <= '0;
      duty_sh_q  <= '0;
      per_act_q  <= '0;
      duty_act_q <= '0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      os_q       <= 1'b0;
      pwm_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (per_we_i)  per_sh_q  <= wdata_i;
      if (duty_we_i) duty_sh_q <= wdata_i;
      per_act_q  <= per_act_d;
      duty_act_q <= duty_act_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      os_q       <= os_d;
      pwm_q      <= pwm_d;
      done_q     <= done_d;
    end
  end

  assign per_sh_o  = per_sh_q;
  assign duty_sh_o = duty_sh_q;
  assign pwm_o     = pwm_q;
  assign done_o    = done_q;

endmodule

// File: rtl/bp_pwm_multi.sv
// rtl/bp_pwm_multi.sv - multi-channel PWM on the MCU parallel bus: write sync, decode, CTRL, readback
module bp_pwm_multi
  import bp_pwm_pkg::*;
#(
  parameter int                   CHANNELS   = 4,
  parameter int                   CNT_WIDTH  = 16,
  parameter int                   DATA_WIDTH = 16,
  parameter int                   ADD_WIDTH  = 6,
  parameter logic [ADD_WIDTH-1:0] BASE_ADD   = 6'h05
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mc_we_n,
  input  logic [ADD_WIDTH-1:0]  mc_add,
  input  logic [DATA_WIDTH-1:0] mc_data_in,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic [CHANNELS-1:0]   oneshot_done,
  output logic                  busy
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 we_s1_q, we_s2_q, we_s3_q;
  logic                 wr_stb;
  logic [ADD_WIDTH-1:0] ofs;
  reg_kind_e            kind;
  logic [CH_W-1:0]      sel_ch;
  logic [CHANNELS-1:0]  en_q, en_d, os_q, os_d, clr;
  logic [CNT_WIDTH-1:0] per_sh  [CHANNELS];
  logic [CNT_WIDTH-1:0] duty_sh [CHANNELS];

  // mc_we_n is asynchronous; two flops resynchronise it, the third gives the falling-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_s1_q <= 1'b0;
      we_s2_q <= 1'b0;
      we_s3_q <= 1'b0;
    end else begin
      we_s1_q <= mc_we_n;
      we_s2_q <= we_s1_q;
      we_s3_q <= we_s2_q;
    end
  end

  assign wr_stb = we_s3_q & ~we_s2_q;

  always_comb begin
    ofs    = mc_add - BASE_ADD;
    kind   = REG_NONE;
    sel_ch = '0;
    if (mc_add >= BASE_ADD) begin
      if (ofs == ADD_WIDTH'(CTRL_OFS)) kind = REG_CTRL;
      for (int i = 0; i < CHANNELS; i++) begin
        if (ofs == ADD_WIDTH'(PERIOD_OFS + CH_STRIDE * i)) begin
          kind   = REG_PERIOD;
          sel_ch = CH_W'(i);
        end
        if (ofs == ADD_WIDTH'(DUTY_OFS + CH_STRIDE * i)) begin
          kind   = REG_DUTY;
          sel_ch = CH_W'(i);
        end
      end
    end
  end

  // an MCU write to CTRL overrides a one-shot self-clear landing on the same edge
  always_comb begin
    en_d = en_q & ~clr;
    os_d = os_q;
    if (wr_stb && kind == REG_CTRL) begin
      en_d = mc_data_in[CTRL_EN_LSB +: CHANNELS];
      os_d = mc_data_in[CTRL_OS_LSB +: CHANNELS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q <= '0;
      os_q <= '0;
    end else begin
      en_q <= en_d;
      os_q <= os_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (kind)
      REG_CTRL: begin
        rd_data[CTRL_EN_LSB +: CHANNELS] = en_q;
        rd_data[CTRL_OS_LSB +: CHANNELS] = os_q;
      end
      REG_PERIOD: rd_data = DATA_WIDTH'(per_sh[sel_ch]);
      REG_DUTY:   rd_data = DATA_WIDTH'(duty_sh[sel_ch]);
      default:    rd_data = '0;
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    bp_pwm_channel #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en_q[g]),
      .oneshot_i (os_q[g]),
      .per_we_i  (wr_stb && kind == REG_PERIOD && sel_ch == CH_W'(g)),
      .duty_we_i (wr_stb && kind == REG_DUTY && sel_ch == CH_W'(g)),
      .wdata_i   (mc_data_in[CNT_WIDTH-1:0]),
      .per_sh_o  (per_sh[g]),
      .duty_sh_o (duty_sh[g]),
      .pwm_o     (pwm_out[g]),
      .done_o    (oneshot_done[g]),
      .clr_o     (clr[g])
    );
  end

  assign busy = |en_q;

endmodule

// File: tb/tb_bp_pwm_multi.sv
// tb/tb_bp_pwm_multi.sv - directed self-checking bench for bp_pwm_multi
module tb_bp_pwm_multi;

  localparam logic [5:0] BASE = 6'h05;

  logic        clk;
  logic        rst;
  logic        mc_we_n;
  logic [5:0]  mc_add;
  logic [15:0] mc_data_in;
  logic [15:0] rd_data;
  logic [3:0]  pwm_out;
  logic [3:0]  oneshot_done;
  logic        busy;

  int          n_cmp;
  int          n_bad;
  logic [15:0] exp_reg [9];

  bp_pwm_multi dut (
    .clk          (clk),
    .rst          (rst),
    .mc_we_n      (mc_we_n),
    .mc_add       (mc_add),
    .mc_data_in   (mc_data_in),
    .rd_data      (rd_data),
    .pwm_out      (pwm_out),
    .oneshot_done (oneshot_done),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_hold(input logic [5:0] a, input logic [15:0] d, input int n);
    @(negedge clk);
    mc_add     = a;
    mc_data_in = d;
    mc_we_n    = 1'b0;
    repeat (n) @(negedge clk);
    mc_we_n = 1'b1;
    if (a >= BASE && a <= BASE + 6'd8) begin
      exp_reg[a - BASE] = (a == BASE) ? (d & 16'h0F0F) : d;
    end
  endtask

  task automatic write(input logic [5:0] a, input logic [15:0] d);
    write_hold(a, d, 4);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (pwm_out !== 4'h0) begin n_bad++; $display("FAIL reset_pwm got %h want 0", pwm_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (oneshot_done !== 4'h0) begin n_bad++; $display("FAIL reset_done got %h want 0", oneshot_done); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mc_add = BASE; #1;
    n_cmp++; if (rd_data !== 16'h0000) begin n_bad++; $display("FAIL reset_ctrl got %h want 0000", rd_data); end
  endtask

  task automatic test_basic();
    logic [3:0] got;
    write(BASE + 6'd1, 16'h0001);
    write(BASE + 6'd2, 16'h0001);
    write(BASE, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      got[i] = pwm_out[0];
      if (i < 3) @(negedge clk);
    end
    n_cmp++; if (got !== 4'b0101) begin n_bad++; $display("FAIL basic_toggle got %b want 0101", got); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
    mc_add = BASE + 6'd1; #1;
    n_cmp++; if (rd_data !== 16'h0001) begin n_bad++; $display("FAIL basic_rd_period0 got %h want 0001", rd_data); end
    write(BASE, 16'h0000);
    n_cmp++; if (pwm_out[0] !== 1'b0) begin n_bad++; $display("FAIL basic_disable_pwm got %b want 0", pwm_out[0]); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_disable_busy got %b want 0", busy); end
  endtask

  task automatic test_shadow_swap();
    logic [19:0] got;
    write(BASE + 6'd1, 16'd9);
    write(BASE + 6'd2, 16'd3);
    write(BASE, 16'h0001);
    fork
      for (int i = 0; i < 20; i++) begin
        got[i] = pwm_out[0];
        @(negedge clk);
      end
      write(BASE + 6'd2, 16'd7);
    join
    n_cmp++;
    if (got !== 20'b0001111111_0000000111) begin
      n_bad++; $display("FAIL shadow_swap got %b want %b", got, 20'b0001111111_0000000111);
    end
    write(BASE, 16'h0000);
  endtask

  task automatic test_oneshot();
    logic [7:0] got_pwm, got_done;
    write(BASE + 6'd1, 16'd4);
    write(BASE + 6'd2, 16'd2);
    write(BASE, 16'h0101);
    for (int i = 0; i < 8; i++) begin
      got_pwm[i]  = pwm_out[0];
      got_done[i] = oneshot_done[0];
      @(negedge clk);
    end
    exp_reg[0] = 16'h0100;
    n_cmp++; if (got_pwm !== 8'b0000_0011) begin n_bad++; $display("FAIL oneshot_pwm got %b want 00000011", got_pwm); end
    n_cmp++; if (got_done !== 8'b0010_0000) begin n_bad++; $display("FAIL oneshot_done got %b want 00100000", got_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL oneshot_busy got %b want 0", busy); end
    mc_add = BASE; #1;
    n_cmp++; if (rd_data !== 16'h0100) begin n_bad++; $display("FAIL oneshot_ctrl got %h want 0100", rd_data); end
    write(BASE, 16'h0101);
    @(negedge clk);
    write(BASE, 16'h0101);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL oneshot_mcu_wins_busy got %b want 1", busy); end
    n_cmp++; if (pwm_out[0] !== 1'b1) begin n_bad++; $display("FAIL oneshot_mcu_wins_pwm got %b want 1", pwm_out[0]); end
    write(BASE, 16'h0000);
  endtask

  task automatic test_edges();
    logic [15:0] tp [3];
    logic [15:0] td [3];
    logic        tv [3];
    logic [11:0] got;
    tp[0] = 16'd9; td[0] = 16'd0;  tv[0] = 1'b0;
    tp[1] = 16'd9; td[1] = 16'd12; tv[1] = 1'b1;
    tp[2] = 16'd0; td[2] = 16'd1;  tv[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      write(BASE + 6'd1, tp[c]);
      write(BASE + 6'd2, td[c]);
      write(BASE, 16'h0001);
      for (int i = 0; i < 12; i++) begin
        got[i] = pwm_out[0];
        @(negedge clk);
      end
      n_cmp++;
      if (got !== {12{tv[c]}}) begin
        n_bad++; $display("FAIL edge_case%0d got %b want all %b", c, got, tv[c]);
      end
      write(BASE, 16'h0000);
    end
  endtask

  task automatic test_long_strobe();
    int dones;
    write_hold(BASE + 6'd3, 16'h0055, 20);
    repeat (3) @(negedge clk);
    mc_add = BASE + 6'd3; #1;
    n_cmp++; if (rd_data !== 16'h0055) begin n_bad++; $display("FAIL long_period1 got %h want 0055", rd_data); end
    write(BASE + 6'd1, 16'd1);
    write(BASE + 6'd2, 16'd1);
    dones = 0;
    fork
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (oneshot_done[0] === 1'b1) dones++;
      end
      write_hold(BASE, 16'h0101, 20);
    join
    exp_reg[0] = 16'h0100;
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL long_single_write done_pulses got %0d want 1", dones); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL long_busy got %b want 0", busy); end
  endtask

  task automatic test_unmapped();
    logic [5:0] zaddr [3];
    write(BASE, 16'hFF00);
    mc_add = BASE; #1;
    n_cmp++; if (rd_data !== 16'h0F00) begin n_bad++; $display("FAIL ctrl_mask got %h want 0F00", rd_data); end
    write(6'h3F, 16'hFFFF);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      mc_add = BASE + 6'(k); #1;
      n_cmp++;
      if (rd_data !== exp_reg[k]) begin
        n_bad++; $display("FAIL unmapped_keep_ofs%0d got %h want %h", k, rd_data, exp_reg[k]);
      end
    end
    zaddr[0] = BASE - 6'd1; zaddr[1] = BASE + 6'd9; zaddr[2] = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      mc_add = zaddr[k]; #1;
      n_cmp++;
      if (rd_data !== 16'h0000) begin
        n_bad++; $display("FAIL unmapped_read_%h got %h want 0000", zaddr[k], rd_data);
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL unmapped_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_midrun();
    logic [9:0] got;
    for (int c = 0; c < 4; c++) begin
      write(BASE + 6'(1 + 2 * c), 16'd9);
      write(BASE + 6'(2 + 2 * c), 16'd5);
    end
    write(BASE, 16'h000F);
    n_cmp++; if (pwm_out !== 4'hF) begin n_bad++; $display("FAIL midrun_aligned_start got %h want F", pwm_out); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (pwm_out !== 4'h0) begin n_bad++; $display("FAIL midrun_reset_pwm got %h want 0", pwm_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 9; k++) exp_reg[k] = 16'h0000;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      mc_add = BASE + 6'(k); #1;
      n_cmp++;
      if (rd_data !== 16'h0000) begin
        n_bad++; $display("FAIL postreset_ofs%0d got %h want 0000", k, rd_data);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got[i] = |pwm_out;
    end
    n_cmp++; if (got !== 10'b0) begin n_bad++; $display("FAIL postreset_pwm_low got %b want 0", got); end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    mc_we_n    = 1'b1;
    mc_add     = '0;
    mc_data_in = '0;
    for (int k = 0; k < 9; k++) exp_reg[k] = 16'h0000;
    test_reset();
    test_basic();
    test_shadow_swap();
    test_oneshot();
    test_edges();
    test_long_strobe();
    test_unmapped();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_pwm_multi.md
Name: bp_pwm_multi

Overview:
- Multi-channel PWM generator on the MCU parallel register bus: mc_add, mc_data, mc_we_n.
- Replaces the single fixed PWM with CHANNELS independent channels.
- Per-channel period/duty registers are double-buffered and swap only at period boundaries, so updates are glitch-free.
- Adds a per-channel one-shot mode with a done pulse; the enclosing top maps the outputs onto bpio pins.

Parameters:
CHANNELS, 4, number of PWM channels (1..8)
CNT_WIDTH, 16, counter / period / duty width (<= DATA_WIDTH)
DATA_WIDTH, 16, MCU data bus width
ADD_WIDTH, 6, MCU address bus width
BASE_ADD, 6'h05, address of CTRL register; block occupies BASE_ADD .. BASE_ADD+2*CHANNELS

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
mc_we_n  in  1  MCU write strobe, active-low, asynchronous to clk
mc_add  in  ADD_WIDTH  MCU address, stable while mc_we_n low
mc_data_in  in  DATA_WIDTH  MCU write data, stable while mc_we_n low
rd_data  out  DATA_WIDTH  readback of addressed register (combinational on mc_add)
pwm_out  out  CHANNELS  PWM outputs
oneshot_done  out  CHANNELS  one-clk pulse when a one-shot period completes
busy  out  1  OR of all channel enables

Behaviour:
- Reset is asynchronous, active-low, clock clk. During reset all registers, counters and outputs are 0: pwm_out=0, oneshot_done=0, busy=0.
- Write path:
  - mc_we_n passes through a 2-FF synchroniser, then falling-edge detect.
  - On the detect cycle, mc_add/mc_data_in are sampled and the target register is written.
  - Latency: the register holds the new value at the 3rd rising clk after mc_we_n falls.
  - Exactly one write per low pulse, regardless of pulse length.
  - Unmapped addresses are ignored.
- Register map (offset from BASE_ADD):
  - 0 = CTRL: bits[7:0] enable[ch], bits[15:8] oneshot[ch]. Bits at or above CHANNELS read 0.
  - 1+2*ch = PERIOD_SH[ch].
  - 2+2*ch = DUTY_SH[ch].
- rd_data returns the shadow/CTRL value for a mapped mc_add, else 0.
- Per-channel counter cnt (CNT_WIDTH bits) and active registers P_act, D_act.
- Enable rising edge, seen by the channel on the cycle after the CTRL write lands:
  - cnt=0, P_act<=PERIOD_SH, D_act<=DUTY_SH.
  - pwm_out=1 on that same cycle if D_act would be nonzero.
- Running:
  - pwm_out = (cnt < D_act); this output is registered.
  - cnt increments each clk. When cnt==P_act, cnt wraps to 0 and P_act/D_act reload from the shadows.
  - Period length is P+1 clks; high time is min(D, P+1) clks.
  - D=0: output constantly low. D>P: output constantly high. P=0: cnt stays 0 and reload happens every clk.
- Shadow write on the same cycle as a wrap: the active registers take the pre-write shadow value. The new value applies from the following period.
- Enable cleared: cnt=0 and pwm_out=0 on the next clk, mid-period allowed.
- One-shot (oneshot[ch]=1 when the period starts):
  - At the wrap, enable[ch] self-clears, oneshot_done[ch] pulses for 1 clk, and pwm_out goes low.
  - If an MCU write to CTRL occurs on the same cycle as the self-clear, the MCU write wins.
- Channels are fully independent; there is no phase alignment except that channels enabled by a single CTRL write start on the same clk.
- Wrap-around: counter arithmetic is modulo 2^CNT_WIDTH. P = all-ones is a legal maximum.

Decomposition:
- Package bp_pwm_pkg: register offset constants (CTRL_OFS=0, PERIOD_OFS=1, DUTY_OFS=2, stride 2) and the CTRL bit-field positions.
- Sub-module bp_pwm_channel: counter, active/shadow swap, one-shot logic. Instantiated CHANNELS times.
- Top level holds the write synchroniser, address decode, CTRL register and readback mux.

Test Plan:
- Write PERIOD0=1, DUTY0=1, CTRL=0x0001 -> pwm_out[0] toggles 1,0,1,0 with a 2-clk period; busy=1; rd_data at BASE_ADD+1 = 0x0001.
- Channel 0 running P=9, D=3; write DUTY0=7 mid-period -> current period keeps 3 high clks; next period has 7 high clks; no glitch.
- CTRL=0x0101 with P=4, D=2 -> exactly one pulse of 2 clks; oneshot_done[0] pulses at clk 5; CTRL reads 0x0100; busy=0.
- Edge cases: D=0 -> output constant 0; D=12 with P=9 -> constant 1; P=0, D=1 -> constant 1.
- mc_we_n held low 20 clks with mc_add=BASE_ADD+3, data=0x0055 -> exactly one write; PERIOD1=0x0055; unmapped address 0x3F write -> no register changes.
- Assert rst low mid-period with all channels running -> pwm_out=0 immediately; after release all registers read 0 and outputs stay low.
